// File: rtl/ai_paddle_ctrl.sv
// AI opponent paddle controller: recentres while the ball is travelling away, then tracks
// the ball after a mode-dependent reaction delay, moving at most one bounded step per frame.
module ai_paddle_ctrl #(
    parameter int REACT_CYCLES = 12_587_500,
    parameter int SCREEN_H     = 480,
    parameter int PDL_H        = 64,
    parameter int SQ_SIZE      = 8,
    parameter int STEP_EASY    = 2,
    parameter int STEP_NORM    = 4,
    parameter int STEP_HARD    = 8,
    parameter int DEADBAND     = 2
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] sq_xpos,
    input  logic [9:0] sq_ypos,
    input  logic       sq_xveldir,
    input  logic [1:0] mode,
    output logic [9:0] ai_pdlypos,
    output logic [1:0] ai_state
);

    typedef enum logic [1:0] {
        CENTER = 2'd0,
        REACT  = 2'd1,
        TRACK  = 2'd2
    } state_t;

    localparam logic [9:0]         MAX_POS    = 10'(SCREEN_H - PDL_H);
    localparam logic [9:0]         CENTER_POS = 10'((SCREEN_H - PDL_H) / 2);
    localparam logic signed [10:0] MAX_S      = 11'(SCREEN_H - PDL_H);
    localparam logic signed [10:0] CENTER_S   = 11'((SCREEN_H - PDL_H) / 2);
    localparam logic signed [10:0] Y_OFS      = 11'(SQ_SIZE / 2 - PDL_H / 2);
    localparam logic [10:0]        DB         = 11'(DEADBAND);
    localparam logic [10:0]        S_EASY     = 11'(STEP_EASY);
    localparam logic [10:0]        S_NORM     = 11'(STEP_NORM);
    localparam logic [10:0]        S_HARD     = 11'(STEP_HARD);
    localparam logic [23:0]        LIM_EASY   = 24'(REACT_CYCLES);
    localparam logic [23:0]        LIM_NORM   = 24'(REACT_CYCLES / 2);

    state_t             state, state_nxt;
    logic [9:0]         pos, pos_nxt;
    logic [23:0]        cnt, cnt_nxt;
    logic [1:0]         mode_q, mode_q_nxt;
    logic signed [10:0] target_raw, target;
    logic [23:0]        limit;
    logic [10:0]        track_step;
    logic               unused_xpos;

    assign unused_xpos = ^sq_xpos;

    // One bounded step toward tgt; the step never exceeds the distance, so no overshoot.
    function automatic logic [9:0] move_toward(input logic [9:0] cur,
                                               input logic signed [10:0] tgt,
                                               input logic [10:0] step);
        logic signed [10:0] diff;
        logic [10:0]        mag;
        logic [10:0]        amt;
        logic signed [11:0] cur_s;
        logic signed [11:0] nxt;
        diff  = tgt - $signed({1'b0, cur});
        mag   = diff[10] ? 11'(-diff) : 11'(diff);
        amt   = (mag < step) ? mag : step;
        cur_s = $signed({2'b00, cur});
        if (mag <= DB)
            nxt = cur_s;
        else if (diff[10])
            nxt = cur_s - $signed({1'b0, amt});
        else
            nxt = cur_s + $signed({1'b0, amt});
        if (nxt[11])
            return '0;
        if (nxt > $signed({2'b00, MAX_POS}))
            return MAX_POS;
        return nxt[9:0];
    endfunction

    always_comb begin
        target_raw = $signed({1'b0, sq_ypos}) + Y_OFS;
        if (target_raw[10])
            target = '0;
        else if (target_raw > MAX_S)
            target = MAX_S;
        else
            target = target_raw;

        case (mode_q)
            2'd1:    limit = LIM_EASY;
            2'd2:    limit = LIM_NORM;
            default: limit = '0;
        endcase

        case (mode_q)
            2'd2:    track_step = S_NORM;
            2'd3:    track_step = S_HARD;
            default: track_step = S_EASY;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        cnt_nxt    = cnt;
        mode_q_nxt = mode_q;
        case (state)
            CENTER: begin
                if (frame_tick)
                    pos_nxt = move_toward(pos, CENTER_S, S_EASY);
                if (sq_xveldir && mode != 2'd0) begin
                    mode_q_nxt = mode;
                    cnt_nxt    = '0;
                    state_nxt  = REACT;
                end
            end
            REACT: begin
                cnt_nxt = cnt + 24'd1;
                if (!sq_xveldir)
                    state_nxt = CENTER;
                else if (limit == '0 || cnt >= limit - 24'd1)
                    state_nxt = TRACK;
            end
            TRACK: begin
                if (frame_tick)
                    pos_nxt = move_toward(pos, target, track_step);
                if (!sq_xveldir || mode == 2'd0)
                    state_nxt = CENTER;
            end
            default: state_nxt = CENTER;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state  <= CENTER;
            pos    <= CENTER_POS;
            cnt    <= '0;
            mode_q <= '0;
        end else begin
            state  <= state_nxt;
            pos    <= pos_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_q_nxt;
        end
    end

    assign ai_pdlypos = pos;
    assign ai_state   = state;

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Self-checking bench for ai_paddle_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_ai_paddle_ctrl;

    localparam int RC = 10;

    logic       clk_0      = 1'b0;
    logic       rst        = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] sq_xpos    = '0;
    logic [9:0] sq_ypos    = '0;
    logic       sq_xveldir = 1'b0;
    logic [1:0] mode       = '0;
    logic [9:0] ai_pdlypos;
    logic [1:0] ai_state;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #20 clk_0 = ~clk_0;

    ai_paddle_ctrl #(.REACT_CYCLES(RC)) dut (
        .clk_0      (clk_0),
        .rst        (rst),
        .frame_tick (frame_tick),
        .sq_xpos    (sq_xpos),
        .sq_ypos    (sq_ypos),
        .sq_xveldir (sq_xveldir),
        .mode       (mode),
        .ai_pdlypos (ai_pdlypos),
        .ai_state   (ai_state)
    );

    // Behavioural model: phase 0 = recentring, 1 = waiting out the reaction, 2 = tracking.
    int m_pos   = 208;
    int m_state = 0;
    int m_len   = 0;
    int m_mode  = 0;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int mv(input int p, input int t, input int s);
        int d;
        int ad;
        int a;
        d  = t - p;
        ad = (d < 0) ? -d : d;
        if (ad <= 2) return p;
        a = (ad < s) ? ad : s;
        return clampi(p + ((d < 0) ? -a : a), 0, 416);
    endfunction

    function automatic int tgt_of(input int y);
        return clampi(y + 4 - 32, 0, 416);
    endfunction

    function automatic int step_of(input int md);
        return (md == 3) ? 8 : (md == 2) ? 4 : 2;
    endfunction

    function automatic int react_len(input int md);
        int l;
        l = (md == 1) ? RC : (md == 2) ? RC / 2 : 0;
        return (l < 1) ? 1 : l;
    endfunction

    always @(posedge clk_0) begin
        if (!rst) begin
            m_pos = 208; m_state = 0; m_len = 0; m_mode = 0;
        end else if (m_state == 0) begin
            if (frame_tick) m_pos = mv(m_pos, 208, 2);
            if (sq_xveldir && mode != 2'd0) begin
                m_mode = int'(mode); m_len = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            m_len++;
            if (!sq_xveldir) m_state = 0;
            else if (m_len >= react_len(m_mode)) m_state = 2;
        end else begin
            if (frame_tick) m_pos = mv(m_pos, tgt_of(int'(sq_ypos)), step_of(m_mode));
            if (!sq_xveldir || mode == 2'd0) m_state = 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_0) begin
        if (cmp_en) begin
            checkOutput("model_pos", int'(ai_pdlypos), m_pos);
            checkOutput("model_state", int'(ai_state), m_state);
        end
    end

    task automatic applyStimulus(input logic ft, input int y, input logic xv, input logic [1:0] md);
        frame_tick = ft;
        sq_ypos    = 10'(y);
        sq_xveldir = xv;
        mode       = md;
        sq_xpos    = 10'($urandom_range(0, 639));
        @(negedge clk_0);
    endtask

    task automatic ticks(input int n, input int y, input logic xv, input logic [1:0] md);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, y, xv, md);
            applyStimulus(1'b0, y, xv, md);
        end
    endtask

    initial begin
        logic xv_r;
        logic [1:0] md_r;
        int y_r;

        @(negedge clk_0);
        rst = 1'b0;
        applyStimulus(1'b0, 100, 1'b0, 2'd2);
        cmp_en = 1'b1;
        applyStimulus(1'b0, 100, 1'b0, 2'd2);
        applyStimulus(1'b0, 100, 1'b0, 2'd2);
        checkOutput("reset_pos", int'(ai_pdlypos), 208);
        checkOutput("reset_state", int'(ai_state), 0);
        checkOutput("model_reset_pos", m_pos, 208);
        rst = 1'b1;
        ticks(4, 100, 1'b0, 2'd2);
        checkOutput("center_hold", int'(ai_pdlypos), 208);

        // EASY reaction: REACT for RC cycles, paddle frozen despite frame ticks.
        applyStimulus(1'b0, 200, 1'b1, 2'd1);
        checkOutput("easy_react_enter", int'(ai_state), 1);
        for (int i = 1; i < RC; i++) begin
            applyStimulus(1'(i % 2), 200, 1'b1, 2'd1);
            checkOutput("easy_react_state", int'(ai_state), 1);
            checkOutput("easy_react_pos", int'(ai_pdlypos), 208);
        end
        applyStimulus(1'b0, 200, 1'b1, 2'd1);
        checkOutput("easy_track_entry", int'(ai_state), 2);
        applyStimulus(1'b0, 200, 1'b0, 2'd1);
        checkOutput("away_to_center", int'(ai_state), 0);

        applyStimulus(1'b0, 200, 1'b1, 2'd2);
        for (int i = 1; i < RC / 2; i++) begin
            applyStimulus(1'b0, 200, 1'b1, 2'd2);
            checkOutput("norm_react_state", int'(ai_state), 1);
        end
        applyStimulus(1'b0, 200, 1'b1, 2'd2);
        checkOutput("norm_track_entry", int'(ai_state), 2);
        applyStimulus(1'b0, 200, 1'b0, 2'd2);

        applyStimulus(1'b0, 200, 1'b1, 2'd3);
        checkOutput("hard_react_state", int'(ai_state), 1);
        applyStimulus(1'b0, 200, 1'b1, 2'd3);
        checkOutput("hard_track_entry", int'(ai_state), 2);
        applyStimulus(1'b0, 200, 1'b0, 2'd3);

        // Abort mid-REACT, then the full delay must be served again.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 200, 1'b1, 2'd1);
        applyStimulus(1'b0, 200, 1'b0, 2'd1);
        checkOutput("abort_state", int'(ai_state), 0);
        for (int i = 0; i < RC; i++) begin
            applyStimulus(1'b0, 200, 1'b1, 2'd1);
            checkOutput("restart_react", int'(ai_state), 1);
        end
        applyStimulus(1'b0, 200, 1'b1, 2'd1);
        checkOutput("restart_track_entry", int'(ai_state), 2);
        applyStimulus(1'b0, 200, 1'b0, 2'd1);

        // NORMAL tracking toward target 372 in steps of 4.
        for (int i = 0; i < RC / 2 + 1; i++) applyStimulus(1'b0, 400, 1'b1, 2'd2);
        checkOutput("track_ready", int'(ai_state), 2);
        applyStimulus(1'b1, 400, 1'b1, 2'd2);
        checkOutput("track_step1", int'(ai_pdlypos), 212);
        applyStimulus(1'b0, 400, 1'b1, 2'd2);
        ticks(1, 400, 1'b1, 2'd2);
        checkOutput("track_step2", int'(ai_pdlypos), 216);
        ticks(39, 400, 1'b1, 2'd2);
        checkOutput("track_final", int'(ai_pdlypos), 372);
        checkOutput("model_track_final", m_pos, 372);
        ticks(4, 400, 1'b1, 2'd2);
        checkOutput("track_hold", int'(ai_pdlypos), 372);
        for (int i = 0; i < 8; i++) ticks(1, 398 + int'($urandom_range(0, 4)), 1'b1, 2'd2);
        checkOutput("jitter_hold", int'(ai_pdlypos), 372);

        // HARD clamp to both screen edges.
        applyStimulus(1'b0, 0, 1'b0, 2'd3);
        applyStimulus(1'b0, 0, 1'b1, 2'd3);
        applyStimulus(1'b0, 0, 1'b1, 2'd3);
        checkOutput("clamp_track", int'(ai_state), 2);
        ticks(50, 0, 1'b1, 2'd3);
        checkOutput("clamp_low", int'(ai_pdlypos), 0);
        ticks(55, 472, 1'b1, 2'd3);
        checkOutput("clamp_high", int'(ai_pdlypos), 416);
        ticks(3, 1023, 1'b1, 2'd3);
        checkOutput("clamp_high_extreme", int'(ai_pdlypos), 416);

        // Reset while tracking at 300.
        ticks(17, 328, 1'b1, 2'd3);
        checkOutput("track_300", int'(ai_pdlypos), 300);
        rst = 1'b0;
        applyStimulus(1'b1, 328, 1'b1, 2'd3);
        checkOutput("midtrack_reset_pos", int'(ai_pdlypos), 208);
        checkOutput("midtrack_reset_state", int'(ai_state), 0);
        rst = 1'b1;

        // Mode switched off while tracking: back to CENTER, recentre at 2 px per tick.
        applyStimulus(1'b0, 328, 1'b1, 2'd3);
        applyStimulus(1'b0, 328, 1'b1, 2'd3);
        ticks(14, 328, 1'b1, 2'd3);
        checkOutput("track_300_again", int'(ai_pdlypos), 300);
        applyStimulus(1'b0, 328, 1'b1, 2'd0);
        checkOutput("mode_off_center", int'(ai_state), 0);
        ticks(1, 328, 1'b1, 2'd0);
        checkOutput("recentre_step1", int'(ai_pdlypos), 298);
        ticks(1, 328, 1'b1, 2'd0);
        checkOutput("recentre_step2", int'(ai_pdlypos), 296);

        // Randomized traffic, checked every cycle by the model comparison.
        xv_r = 1'b0;
        md_r = 2'd1;
        y_r  = 240;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) xv_r = ~xv_r;
            if ($urandom_range(0, 59) == 0) md_r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) y_r = int'($urandom_range(0, 1023));
            rst = ($urandom_range(0, 299) != 0);
            applyStimulus(1'($urandom_range(0, 5) == 0), y_r, xv_r, md_r);
        end
        rst = 1'b1;
        applyStimulus(1'b0, y_r, 1'b0, md_r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ai_paddle_ctrl.md
Name: ai_paddle_ctrl

Overview:
Parametrised AI opponent paddle controller, the successor to the single-speed AI block. It tracks the ball after a mode-scaled reaction delay and moves the paddle at most one bounded step per frame tick. It recentres the paddle when the ball travels away. It sits in the game logic between the ball engine and the renderer/collision logic, all in the 25.175 MHz pixel-clock domain.

Parameters:
REACT_CYCLES, 12_587_500, reaction delay in clk_0 cycles for EASY mode (0.5 s at 25.175 MHz)
SCREEN_H, 480, playfield height in pixels
PDL_H, 64, paddle height in pixels
SQ_SIZE, 8, ball square size in pixels
STEP_EASY, 2, max paddle move per frame tick in EASY mode and in recentring
STEP_NORM, 4, max move per frame tick in NORMAL mode
STEP_HARD, 8, max move per frame tick in HARD mode
DEADBAND, 2, no move while |target - position| <= DEADBAND

Ports:
clk_0  in  1  system/pixel clock; single clock domain
rst  in  1  reset; synchronous, active-low
frame_tick  in  1  one-cycle pulse per video frame; paddle moves only on this cycle
sq_xpos  in  10  ball x-coordinate (unused for control; kept for interface parity with the ball engine)
sq_ypos  in  10  ball y-coordinate (top edge)
sq_xveldir  in  1  1 = ball travelling toward the AI paddle
mode  in  2  0 = OFF, 1 = EASY, 2 = NORMAL, 3 = HARD
ai_pdlypos  out  10  paddle top-edge y position
ai_state  out  2  0 = CENTER, 1 = REACT, 2 = TRACK (debug/LED)

Behaviour:
- Reset (rst = 0 at a clk_0 edge): ai_pdlypos = (SCREEN_H-PDL_H)/2 = 208, state = CENTER, reaction counter = 0, latched mode = 0. Reset takes priority over all other activity, including mid-REACT and mid-TRACK.
- center = (SCREEN_H-PDL_H)/2.
- target = sq_ypos + SQ_SIZE/2 - PDL_H/2:
  - Evaluate in 11-bit signed arithmetic.
  - Clamp to [0, SCREEN_H-PDL_H].
- diff = target - ai_pdlypos, in 11-bit signed arithmetic.
- Move rule, applied only on frame_tick:
  - If |diff| <= DEADBAND: hold.
  - Otherwise move by min(step, |diff|) in the sign of diff.
  - Clamp the result to [0, SCREEN_H-PDL_H].
  - The position never overshoots the target.
- FSM:
  - CENTER:
    - Move toward center using step STEP_EASY; DEADBAND applies.
    - If sq_xveldir = 1 and mode != 0: latch mode into mode_q, clear the counter, go to REACT.
    - mode = 0 keeps the FSM in CENTER permanently.
  - REACT:
    - Paddle holds position.
    - Counter increments every clk_0 cycle.
    - Delay limit by mode_q: EASY = REACT_CYCLES; NORMAL = REACT_CYCLES/2; HARD = 0.
    - HARD: go to TRACK on the next cycle.
    - Otherwise go to TRACK on the cycle where counter = limit-1, i.e. the first TRACK cycle is limit+1 cycles after REACT entry.
    - If sq_xveldir drops to 0 before expiry, go to CENTER. The counter is not preserved.
  - TRACK:
    - Move toward target using the step for mode_q, on frame_tick only.
    - If sq_xveldir = 0, go to CENTER on the next cycle.
    - If mode becomes 0, go to CENTER.
    - A mode change to any other nonzero value is ignored until the next REACT entry.
- frame_tick on the same cycle as a state transition:
  - The move uses the rule of the current (pre-transition) state.
  - In REACT the paddle holds position regardless of frame_tick.
- Counter width: 24 bits, sufficient for REACT_CYCLES <= 2^24-1.
- ai_pdlypos and ai_state are registered outputs. A position change is visible one cycle after the frame_tick cycle.
- Ball at the screen edges: the target clamp keeps the paddle fully on-screen, e.g. sq_ypos = 0 gives target 0 and sq_ypos = 472 gives target 416.

Test Plan:
- Reset/recentre: hold rst = 0 for 3 cycles with mode = 2 → ai_pdlypos = 208 and ai_state = 0. Then with sq_xveldir = 0, mode = 2 and frame_ticks → position stays 208.
- Reaction delay (REACT_CYCLES = 10, mode = 1): raise sq_xveldir at cycle T → ai_state = 1 for cycles T+1..T+10, and = 2 at T+11. Paddle unchanged throughout REACT even with frame_tick pulses. Mode = 2 → TRACK at T+6; mode = 3 → TRACK at T+2.
- Tracking step (mode = 2, position 208, sq_ypos = 400) → target 372. Each frame_tick moves +4: 212, 216, … Final step lands on 372 exactly. Then hold with sq_ypos constant, and hold with a ±2 ball jitter inside DEADBAND.
- Clamp (mode = 3, sq_ypos = 0 then 472) → paddle settles at 0, then at 416. Never outside [0, 416]; no underflow wrap.
- Abort: sq_xveldir drops to 0 mid-REACT → ai_state = 0 next cycle. Re-raise → counter restarts from 0 and the full delay is observed.
- Edge cases:
  - Reset asserted mid-TRACK at position 300 → 208 and CENTER on the next cycle.
  - mode switched to 0 mid-TRACK → CENTER, with recentring at 2 px per tick.
